mem_read_arbiter: RTL and testbench
===================================

// Module: mem_read_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single read port of the feature memory among three
//  consumers: 0 = PE array, 1 = 3x3 stage, 2 = 2x2 stage. Consumers can run concurrently
//  once the phase sequencer releases their resets. Grants one request per cycle with a
//  bounded burst. Routes read data back to the issuing consumer after the fixed memory
//  read latency.
// PARAMETERS
//  ADDR_W     10  memory address width
//  DATA_W     8   memory data width
//  RD_LAT     1   memory read latency in cycles, from mem_en to mem_rdata valid (1..4)
//  BURST_MAX  4   max consecutive grants to one requester while another is waiting (>=1)
// PORTS
//  clk        in   1           system clock
//  rst        in   1           asynchronous active-low reset
//  en         in   3           per-requester enable (driven by sequencer: en[i] = ~rst_<stage>)
//  req        in   3           read request, level; held until granted
//  addr_in    in   3*ADDR_W    request addresses; requester i at [i*ADDR_W +: ADDR_W]
//  gnt        out  3           one-hot grant; request accepted when req[i] & gnt[i]
//  mem_en     out  1           memory read enable (= |gnt)
//  mem_addr   out  ADDR_W      address of granted requester (0 when no grant)
//  mem_rdata  in   DATA_W      memory read data, valid RD_LAT cycles after mem_en
//  rvalid     out  3           one-hot read-return strobe, 1 cycle
//  rdata      out  DATA_W      returned data, registered copy of mem_rdata
// BEHAVIOUR
//  - Reset (rst=0, async):
//    - gnt=0, mem_en=0, mem_addr=0, rvalid=0, rdata=0.
//    - Tag pipeline cleared; in-flight reads are discarded and never return.
//    - Pointer last=2, so requester 0 has first priority. Burst count cnt=0.
//  - Effective request r = req & en. Grant is combinational from r, last and cnt, and is
//    forced to 0 while rst=0. Zero-cycle grant latency.
//  - Arbitration (per cycle):
//    - Owner keeps the grant if r[last]=1 and either cnt<BURST_MAX-1 or no other r bit is set.
//    - Otherwise grant goes to the first set bit of r, scanning last+1, last+2, last+3 (mod 3).
//    - If r=0, no grant; last and cnt are unchanged.
//  - State update on each granted cycle:
//    - Same owner: last unchanged; cnt = min(cnt+1, BURST_MAX-1) (saturating).
//    - New owner: last = new owner; cnt = 0.
//  - BURST_MAX=1 gives pure round-robin: the owner rotates each cycle while others wait.
//  - Read return:
//    - Tag shift register RD_LAT deep carries {valid, 2-bit id} for each grant.
//    - On the cycle mem_rdata is valid, rdata<=mem_rdata and rvalid[id]<=1 (registered).
//    - Total latency from accepted request to rvalid: RD_LAT+1 cycles.
//  - Back-to-back grants are fully pipelined: one return per cycle, in issue order.
//  - en[i] falling with reads in flight: those returns are still delivered. The consumer
//    is in reset and ignores them.
//  - en[i]=0 masks req[i]. A masked requester never wins and never holds ownership.
//  - Simultaneous owner drop and new request: arbitration uses the current-cycle r only,
//    with no idle bubble.
// TESTING
//  1. RD_LAT=1, req=001, addr 0..4 on consecutive cycles, mem[k]=k+8 -> gnt=001 every
//     cycle; rvalid=001 with rdata 8..12, starting 2 cycles after the first grant.
//  2. BURST_MAX=1, req=111 held 9 cycles -> gnt sequence 001,010,100 repeated 3 times.
//  3. BURST_MAX=4, req=111 held 12 cycles -> gnt 001 x4, 010 x4, 100 x4.
//  4. BURST_MAX=4: req=001 for 6 cycles, then req=011 -> gnt 001 for 6 cycles, then 010
//     on the next cycle (cnt saturated).
//  5. en=101, req=111 -> gnt alternates 001,100 per burst; gnt[1] and rvalid[1] never
//     assert.
//  6. RD_LAT=2: two grants issued, then rst pulsed low for 1 cycle -> rvalid stays 0
//     throughout and after release; first grant after release is to requester 0.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter for the shared feature-memory read port.
// Three consumers, bounded bursts, read data routed back by a tag pipeline.
module mem_read_arbiter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          en,
  input  logic [2:0]          req,
  input  logic [3*ADDR_W-1:0] addr_in,
  output logic [2:0]          gnt,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(BURST_MAX - 1);

  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Set by the first grant after reset; until then nobody owns the port, so
  // requester 0 wins first even though last points at 2.
  logic             own_q, own_d;
  logic [2:0]       r, others;
  logic [1:0]       win, idx;
  logic             hit;
  logic [2:0]       tag_q [RD_LAT];
  logic [2:0]       tag_out;

  // Arbitration: keep the owner within its burst budget, else rotate from last+1.
  always_comb begin
    r      = req & en;
    others = r;
    others[last_q] = 1'b0;
    hit    = 1'b0;
    win    = last_q;
    idx    = last_q;
    if (own_q && r[last_q] && ((cnt_q < CntMax) || (others == 3'b000))) begin
      hit = 1'b1;
      win = last_q;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        idx = 2'((int'(last_q) + k) % 3);
        if (!hit && r[idx]) begin
          hit = 1'b1;
          win = idx;
        end
      end
    end
    gnt    = (hit && rst) ? (3'b001 << win) : 3'b000;
    mem_en = |gnt;
  end

  // Address mux, zero when nothing is granted.
  always_comb begin
    mem_addr = '0;
    for (int i = 0; i < 3; i++) begin
      if (gnt[i]) mem_addr = addr_in[i*ADDR_W +: ADDR_W];
    end
  end

  // Ownership and burst-count next state; idle cycles leave them untouched.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    own_d  = own_q;
    if (mem_en) begin
      own_d = 1'b1;
      if (own_q && (win == last_q)) begin
        cnt_d = (cnt_q < CntMax) ? cnt_q + 1'b1 : cnt_q;
      end else begin
        last_d = win;
        cnt_d  = '0;
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 2'd2;
      cnt_q  <= '0;
      own_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      own_q  <= own_d;
    end
  end

  assign tag_out = tag_q[RD_LAT-1];

  // Tag pipeline {valid, id}; its tail lines up with valid mem_rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) tag_q[i] <= 3'b000;
    end else begin
      tag_q[0] <= {mem_en, win};
      for (int i = 1; i < int'(RD_LAT); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Registered read return to the issuing consumer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid <= 3'b000;
      rdata  <= '0;
    end else begin
      rvalid <= tag_out[2] ? (3'b001 << tag_out[1:0]) : 3'b000;
      if (tag_out[2]) rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench: three arbiter instances with different RD_LAT/BURST_MAX
// share the stimulus; each test task checks the instance it targets.
module tb_mem_read_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    en  = 3'b111;
  logic [2:0]    req = 3'b000;
  logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [3*AW-1:0] addr_in;

  logic [2:0] gnt_a, gnt_b, gnt_c, rvalid_a, rvalid_b, rvalid_c;
  logic       mem_en_a, mem_en_b, mem_en_c;
  logic [AW-1:0] mem_addr_a, mem_addr_b, mem_addr_c;
  logic [DW-1:0] mem_rdata_a, mem_rdata_b, mem_rdata_c, mem_pipe_c;
  logic [DW-1:0] rdata_a, rdata_b, rdata_c;

  int n_cmp = 0;
  int n_err = 0;

  assign addr_in = {addr2, addr1, addr0};

  always #5 clk = ~clk;

  // Memory models: mem[k] = k + 8, read latency 1 for a/b, 2 for c.
  always @(posedge clk) begin
    mem_rdata_a <= mem_addr_a[7:0] + 8'd8;
    mem_rdata_b <= mem_addr_b[7:0] + 8'd8;
    mem_pipe_c  <= mem_addr_c[7:0] + 8'd8;
    mem_rdata_c <= mem_pipe_c;
  end

  mem_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .BURST_MAX(4)) u_a (
    .clk(clk), .rst(rst), .en(en), .req(req), .addr_in(addr_in), .gnt(gnt_a),
    .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
    .rvalid(rvalid_a), .rdata(rdata_a)
  );

  mem_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .BURST_MAX(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .req(req), .addr_in(addr_in), .gnt(gnt_b),
    .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
    .rvalid(rvalid_b), .rdata(rdata_b)
  );

  mem_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .BURST_MAX(4)) u_c (
    .clk(clk), .rst(rst), .en(en), .req(req), .addr_in(addr_in), .gnt(gnt_c),
    .mem_en(mem_en_c), .mem_addr(mem_addr_c), .mem_rdata(mem_rdata_c),
    .rvalid(rvalid_c), .rdata(rdata_c)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 3'b000;
    en  = 3'b111;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 3'b111;
    #1;
    n_cmp++; if (gnt_a !== 3'b000) begin n_err++; $display("FAIL reset_gnt_a got %b want 000", gnt_a); end
    n_cmp++; if (gnt_b !== 3'b000) begin n_err++; $display("FAIL reset_gnt_b got %b want 000", gnt_b); end
    n_cmp++; if (gnt_c !== 3'b000) begin n_err++; $display("FAIL reset_gnt_c got %b want 000", gnt_c); end
    n_cmp++; if (mem_en_a !== 1'b0) begin n_err++; $display("FAIL reset_mem_en got %b want 0", mem_en_a); end
    n_cmp++; if (mem_addr_a !== '0) begin n_err++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr_a); end
    n_cmp++; if (rvalid_a !== 3'b000) begin n_err++; $display("FAIL reset_rvalid got %b want 000", rvalid_a); end
    n_cmp++; if (rdata_a !== '0) begin n_err++; $display("FAIL reset_rdata got %0d want 0", rdata_a); end
    @(negedge clk);
    req = 3'b000;
    rst = 1'b1;
  endtask

  // Single requester streaming addresses 0..4; returns 8..12 two cycles later.
  task automatic test_single_stream();
    logic [2:0] eg, ev;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req   = (c < 5) ? 3'b001 : 3'b000;
      addr0 = AW'(c);
      #1;
      eg = (c < 5) ? 3'b001 : 3'b000;
      ev = (c >= 2 && c <= 6) ? 3'b001 : 3'b000;
      n_cmp++; if (gnt_a !== eg) begin n_err++; $display("FAIL stream_gnt c=%0d got %b want %b", c, gnt_a, eg); end
      n_cmp++; if (mem_addr_a !== ((c < 5) ? AW'(c) : AW'(0))) begin
        n_err++; $display("FAIL stream_addr c=%0d got %0d want %0d", c, mem_addr_a, (c < 5) ? c : 0);
      end
      n_cmp++; if (rvalid_a !== ev) begin n_err++; $display("FAIL stream_rvalid c=%0d got %b want %b", c, rvalid_a, ev); end
      if (ev[0]) begin
        n_cmp++; if (rdata_a !== DW'(c + 6)) begin n_err++; $display("FAIL stream_rdata c=%0d got %0d want %0d", c, rdata_a, c + 6); end
      end
    end
    addr0 = '0;
  endtask

  // BURST_MAX=1: pure rotation.
  task automatic test_pure_rr();
    logic [2:0] eg;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req = 3'b111;
      #1;
      eg = 3'b001 << (c % 3);
      n_cmp++; if (gnt_b !== eg) begin n_err++; $display("FAIL rr_gnt c=%0d got %b want %b", c, gnt_b, eg); end
    end
    req = 3'b000;
  endtask

  // BURST_MAX=4: four grants per owner under full contention.
  task automatic test_burst();
    logic [2:0] eg;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req = 3'b111;
      #1;
      eg = 3'b001 << (c / 4);
      n_cmp++; if (gnt_a !== eg) begin n_err++; $display("FAIL burst_gnt c=%0d got %b want %b", c, gnt_a, eg); end
    end
    req = 3'b000;
  endtask

  // Saturated count hands over immediately once a competitor appears.
  task automatic test_back_to_back_saturate();
    logic [2:0] eg;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req = (c < 6) ? 3'b001 : 3'b011;
      #1;
      eg = (c < 6) ? 3'b001 : 3'b010;
      n_cmp++; if (gnt_a !== eg) begin n_err++; $display("FAIL sat_gnt c=%0d got %b want %b", c, gnt_a, eg); end
    end
    req = 3'b000;
  endtask

  // en[1]=0 masks requester 1 entirely.
  task automatic test_en_mask();
    logic [2:0] hist [12];
    logic [2:0] eg, ev;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      en  = 3'b101;
      req = 3'b111;
      #1;
      eg = ((c / 4) % 2 == 0) ? 3'b001 : 3'b100;
      hist[c] = eg;
      ev = (c >= 2) ? hist[c-2] : 3'b000;
      n_cmp++; if (gnt_a !== eg) begin n_err++; $display("FAIL mask_gnt c=%0d got %b want %b", c, gnt_a, eg); end
      n_cmp++; if (rvalid_a !== ev) begin n_err++; $display("FAIL mask_rvalid c=%0d got %b want %b", c, rvalid_a, ev); end
    end
    req = 3'b000;
    en  = 3'b111;
  endtask

  // RD_LAT=2: reset mid-flight discards returns, then requester 0 wins first.
  task automatic test_reset_inflight();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rst = (c == 2) ? 1'b0 : 1'b1;
      req = (c < 2) ? 3'b001 : ((c == 7) ? 3'b111 : 3'b000);
      #1;
      n_cmp++; if (rvalid_c !== 3'b000) begin n_err++; $display("FAIL flush_rvalid c=%0d got %b want 000", c, rvalid_c); end
      if (c < 2) begin
        n_cmp++; if (gnt_c !== 3'b001) begin n_err++; $display("FAIL flush_pre_gnt c=%0d got %b want 001", c, gnt_c); end
      end
      if (c == 7) begin
        n_cmp++; if (gnt_c !== 3'b001) begin n_err++; $display("FAIL flush_post_gnt got %b want 001", gnt_c); end
      end
    end
    req = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_pure_rr();
    test_burst();
    test_back_to_back_saturate();
    test_en_mask();
    test_reset_inflight();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
